// File: rtl/traffic_lights_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package : tl_pkg
//  Shared types and widths for the traffic-light command sequencer.
//  Revision: 1.0
// ============================================================================
package tl_pkg;

  localparam int CMD_W      = 3;
  localparam int DATA_W     = 16;
  localparam int LIST_DEPTH = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_ON           = 3'd0,
    CMD_OFF          = 3'd1,
    CMD_NOTRANSITION = 3'd2,
    CMD_SET_GREEN    = 3'd3,
    CMD_SET_RED      = 3'd4,
    CMD_SET_YELLOW   = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    OP_ON     = 2'd0,
    OP_OFF    = 2'd1,
    OP_CONFIG = 2'd2,
    OP_RSVD   = 2'd3
  } req_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/traffic_lights_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface : traffic_lights_cmd_seq_if
//  Host request handshake plus controller command bus.
//  Revision: 1.0
// ============================================================================
interface traffic_lights_cmd_seq_if;
  import tl_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_op_i;
  logic [DATA_W-1:0] req_green_i;
  logic [DATA_W-1:0] req_red_i;
  logic [DATA_W-1:0] req_yellow_i;
  logic [CMD_W-1:0]  cmd_type_o;
  logic              cmd_valid_o;
  logic [DATA_W-1:0] cmd_data_o;
  logic              busy_o;
  logic              done_o;

  // master = the sequencer, slave = the host side
  modport master (
    input  req_valid_i, req_op_i, req_green_i, req_red_i, req_yellow_i,
    output req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o, done_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_green_i, req_red_i, req_yellow_i,
    input  req_ready_o, cmd_type_o, cmd_valid_o, cmd_data_o, busy_o, done_o
  );

endinterface
`default_nettype wire

// File: rtl/traffic_lights_cmd_seq_gap_timer.sv
`default_nettype none
// ============================================================================
//  Module  : tl_cmd_gap_timer
//  Loadable down-counter timing the idle gap between commands.
//  Revision: 1.0
// ============================================================================
module tl_cmd_gap_timer #(
  parameter int CYCLES = 1
) (
  input  wire logic clk_i,
  input  wire logic srst_i,
  input  wire logic start_i,
  output logic      expired_o
);

  localparam int c_cnt_w = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(CYCLES);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt <= '0;
    end else if (start_i) begin
      r_cnt <= c_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  // The count is already CYCLES in the first gap cycle, so 1 marks the last one
  assign expired_o = (r_cnt <= c_one);

endmodule
`default_nettype wire

// File: rtl/traffic_lights_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module  : traffic_lights_cmd_seq
//  Serialises ON/OFF/CONFIG host requests into single-cycle controller
//  commands. Optional TL_CMD_SEQ_SKIP_ZERO_EN drops zero-period writes.
//  Revision: 1.0
// ============================================================================
module traffic_lights_cmd_seq
  import tl_pkg::*;
#(
  parameter int CMD_GAP_CYCLES = 1
) (
  input  wire logic                 clk_i,
  input  wire logic                 srst_i,
  traffic_lights_cmd_seq_if.master  bus
);

  localparam logic c_has_gap = (CMD_GAP_CYCLES > 0);

  seq_state_t        r_state;
  seq_state_t        w_next;
  cmd_type_t         r_list [LIST_DEPTH];
  cmd_type_t         w_list [LIST_DEPTH];
  logic [2:0]        r_len;
  logic [2:0]        w_len;
  logic [2:0]        r_idx;
  logic [DATA_W-1:0] r_green;
  logic [DATA_W-1:0] r_red;
  logic [DATA_W-1:0] r_yellow;
  logic              w_handshake;
  logic              w_last;
  logic              w_cmd_valid;
  logic              w_done;
  logic              w_gap_expired;
  logic              w_keep_g;
  logic              w_keep_r;
  logic              w_keep_y;
  cmd_type_t         w_cur;
  logic [DATA_W-1:0] w_cur_data;

  assign w_handshake = bus.req_valid_i && (r_state == ST_IDLE);
  assign w_last      = (r_len == 3'd0) || (r_idx == (r_len - 3'd1));

`ifdef TL_CMD_SEQ_SKIP_ZERO_EN
  assign w_keep_g = |bus.req_green_i;
  assign w_keep_r = |bus.req_red_i;
  assign w_keep_y = |bus.req_yellow_i;
`else
  assign w_keep_g = 1'b1;
  assign w_keep_r = 1'b1;
  assign w_keep_y = 1'b1;
`endif

  // Command list built from the live request; captured only on handshake
  always_comb begin
    for (int i = 0; i < LIST_DEPTH; i++) w_list[i] = CMD_ON;
    w_len = 3'd0;
    case (req_op_t'(bus.req_op_i))
      OP_ON:  begin w_list[0] = CMD_ON;  w_len = 3'd1; end
      OP_OFF: begin w_list[0] = CMD_OFF; w_len = 3'd1; end
      OP_CONFIG: begin
        w_list[w_len] = CMD_NOTRANSITION; w_len = w_len + 3'd1;
        if (w_keep_g) begin w_list[w_len] = CMD_SET_GREEN;  w_len = w_len + 3'd1; end
        if (w_keep_r) begin w_list[w_len] = CMD_SET_RED;    w_len = w_len + 3'd1; end
        if (w_keep_y) begin w_list[w_len] = CMD_SET_YELLOW; w_len = w_len + 3'd1; end
        w_list[w_len] = CMD_ON; w_len = w_len + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_valid = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_handshake) w_next = ST_ISSUE;
      ST_ISSUE: begin
        w_cmd_valid = (r_len != 3'd0);
        if (w_last) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (c_has_gap) begin
          w_next = ST_GAP;
        end
      end
      ST_GAP:   if (w_gap_expired) w_next = ST_ISSUE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int i = 0; i < LIST_DEPTH; i++) r_list[i] <= CMD_ON;
      r_len    <= 3'd0;
      r_idx    <= 3'd0;
      r_green  <= '0;
      r_red    <= '0;
      r_yellow <= '0;
    end else if (w_handshake) begin
      for (int i = 0; i < LIST_DEPTH; i++) r_list[i] <= w_list[i];
      r_len    <= w_len;
      r_idx    <= 3'd0;
      r_green  <= bus.req_green_i;
      r_red    <= bus.req_red_i;
      r_yellow <= bus.req_yellow_i;
    end else if ((r_state == ST_ISSUE) && !w_last) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  tl_cmd_gap_timer #(
    .CYCLES    (CMD_GAP_CYCLES)
  ) u_gap_timer (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .start_i   (r_state == ST_ISSUE),
    .expired_o (w_gap_expired)
  );

  assign w_cur = r_list[r_idx];

  always_comb begin
    w_cur_data = '0;
    case (w_cur)
      CMD_SET_GREEN:  w_cur_data = r_green;
      CMD_SET_RED:    w_cur_data = r_red;
      CMD_SET_YELLOW: w_cur_data = r_yellow;
      default:        w_cur_data = '0;
    endcase
  end

  assign bus.req_ready_o = (r_state == ST_IDLE);
  assign bus.busy_o      = (r_state != ST_IDLE);
  assign bus.cmd_valid_o = w_cmd_valid;
  assign bus.cmd_type_o  = w_cmd_valid ? w_cur : CMD_ON;
  assign bus.cmd_data_o  = w_cmd_valid ? w_cur_data : '0;
  assign bus.done_o      = w_done;

endmodule
`default_nettype wire
